// File: rtl/vx_scalar_ibuffer_pkg.sv
// Shared types for the scalar instruction buffer: the per-instruction payload
// and the issue-slot warp-index sizing helper.
package vx_scalar_ibuffer_pkg;

    localparam int NUM_THREADS = 4;
    localparam int NUM_WARPS   = 4;
    localparam int ISSUE_WIDTH = 1;
    localparam int UUID_W      = 44;

    function automatic int log2up(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PER_ISSUE_WARPS = NUM_WARPS / ISSUE_WIDTH;
    localparam int ISSUE_WIS_W     = log2up(PER_ISSUE_WARPS);

    typedef struct packed {
        logic [UUID_W-1:0]      uuid;
        logic [ISSUE_WIS_W-1:0] wis;
        logic [NUM_THREADS-1:0] tmask;
        logic [2:0]             ex_type;
        logic [3:0]             op_type;
        logic [2:0]             op_mod;
        logic                   wb;
        logic                   use_pc;
        logic                   use_imm;
        logic [31:0]            pc;
        logic [31:0]            imm;
        logic [5:0]             rd;
        logic [5:0]             rs1;
        logic [5:0]             rs2;
        logic [5:0]             rs3;
    } ibuf_data_t;

endpackage

// File: rtl/vx_scalar_ibuffer_if.sv
// valid/data/ready channel carrying one decoded instruction.
interface vx_scalar_ibuffer_if;
    import vx_scalar_ibuffer_pkg::*;

    logic       valid;
    ibuf_data_t data;
    logic       ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/vx_scalar_ibuffer_fifo.sv
// Single-warp DEPTH-entry FIFO; caller guarantees no push when full and no
// pop when empty.
module vx_scalar_ibuffer_fifo
    import vx_scalar_ibuffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  ibuf_data_t din,
    output ibuf_data_t dout,
    output logic       full,
    output logic       empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    ibuf_data_t       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is left unreset; count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/vx_scalar_ibuffer.sv
// Per-issue-slot instruction buffer: per-warp FIFOs, round-robin warp pick,
// registered output stage toward scoreboard/dispatch.
module vx_scalar_ibuffer
    import vx_scalar_ibuffer_pkg::*;
#(
    parameter int THREAD_CNT = NUM_THREADS,
    parameter int ISSUE_CNT  = ISSUE_WIDTH,
    parameter int WARP_CNT   = NUM_WARPS,
    parameter int DEPTH      = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    vx_scalar_ibuffer_if.slave                   decode,
    input  logic [log2up(WARP_CNT/ISSUE_CNT)-1:0] decode_wis,
    vx_scalar_ibuffer_if.master                  ibuf,
    output logic [WARP_CNT/ISSUE_CNT-1:0]        ibuf_pop,
    output logic [WARP_CNT/ISSUE_CNT-1:0]        ibuf_empty
);
    localparam int PER_WARPS = WARP_CNT / ISSUE_CNT;
    localparam int WIS_W     = log2up(PER_WARPS);

    // The payload struct is sized from the package, so the overrides must agree.
    if (THREAD_CNT != NUM_THREADS || WIS_W != ISSUE_WIS_W ||
        DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_cfg_err
        $error("vx_scalar_ibuffer: parameters inconsistent with package payload or DEPTH");
    end

    ibuf_data_t           heads [PER_WARPS];
    logic [PER_WARPS-1:0] full;
    logic [PER_WARPS-1:0] push;

    assign decode.ready = !full[decode_wis];

    for (genvar w = 0; w < PER_WARPS; w++) begin : g_warp
        assign push[w] = decode.valid && decode.ready && (decode_wis == WIS_W'(w));

        vx_scalar_ibuffer_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push[w]),
            .pop   (ibuf_pop[w]),
            .din   (decode.data),
            .dout  (heads[w]),
            .full  (full[w]),
            .empty (ibuf_empty[w])
        );
    end

    logic             out_valid;
    ibuf_data_t       out_data;
    logic [WIS_W-1:0] rr_ptr;
    logic [WIS_W-1:0] sel;
    logic [WIS_W-1:0] next_rr;
    logic             found;
    logic             load_en;
    ibuf_data_t       sel_data;
    int               idx;

    assign load_en = !out_valid || ibuf.ready;

    // Circular scan starting at rr_ptr; first non-empty warp wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int i = 0; i < PER_WARPS; i++) begin
            idx = (int'(rr_ptr) + i) % PER_WARPS;
            if (!found && !ibuf_empty[idx]) begin
                found = 1'b1;
                sel   = WIS_W'(idx);
            end
        end
        next_rr  = WIS_W'((int'(sel) + 1) % PER_WARPS);
        sel_data = heads[sel];
        sel_data.wis = sel;
        ibuf_pop = (load_en && found) ? (PER_WARPS'(1) << sel) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            rr_ptr    <= '0;
        end else if (load_en) begin
            out_valid <= found;
            if (found) begin
                out_data <= sel_data;
                rr_ptr   <= next_rr;
            end
        end
    end

    assign ibuf.valid = out_valid;
    assign ibuf.data  = out_data;
endmodule

// File: tb/tb_vx_scalar_ibuffer.sv
// Directed bench for vx_scalar_ibuffer with a queue-based output scoreboard.
module tb_vx_scalar_ibuffer;
    import vx_scalar_ibuffer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] decode_wis;
    logic [3:0] ibuf_pop;
    logic [3:0] ibuf_empty;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         stall;
    ibuf_data_t exp_q [$];
    ibuf_data_t e;

    always #5 clk = ~clk;

    vx_scalar_ibuffer_if decode_bus ();
    vx_scalar_ibuffer_if ibuf_bus ();

    vx_scalar_ibuffer #(.THREAD_CNT(4), .ISSUE_CNT(1), .WARP_CNT(4), .DEPTH(2)) dut (
        .clk        (clk),
        .reset      (rst),
        .decode     (decode_bus),
        .decode_wis (decode_wis),
        .ibuf       (ibuf_bus),
        .ibuf_pop   (ibuf_pop),
        .ibuf_empty (ibuf_empty)
    );

    // Pushed copies carry a wrong wis so the overwrite by the source warp is visible.
    function automatic ibuf_data_t mk(input int w, input logic [31:0] pc, input bit as_pushed);
        ibuf_data_t d;
        d       = '0;
        d.uuid  = 44'(pc) ^ 44'h5A5;
        d.tmask = 4'hF;
        d.pc    = pc;
        d.imm   = ~pc;
        d.rd    = 6'(w + 3);
        d.wis   = as_pushed ? 2'(w + 1) : 2'(w);
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input int w, input logic [31:0] pc, output int stalled);
        stalled          = 0;
        decode_wis       = 2'(w);
        decode_bus.data  = mk(w, pc, 1'b1);
        decode_bus.valid = 1'b1;
        @(negedge clk);
        while (!decode_bus.ready && stalled < 50) begin
            stalled++;
            @(negedge clk);
        end
        if (stalled >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: warp %0d pc %0h never accepted", w, pc);
        end
        @(posedge clk);
        #1;
        decode_bus.valid = 1'b0;
    endtask

    task automatic expect_out(input int w, input logic [31:0] pc);
        exp_q.push_back(mk(w, pc, 1'b0));
    endtask

    always @(negedge clk) begin
        if (!rst && ibuf_bus.valid && ibuf_bus.ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got wis=%0d pc=%0h, required no output",
                         ibuf_bus.data.wis, ibuf_bus.data.pc);
            end else begin
                e = exp_q.pop_front();
                chk("out_wis",  64'(ibuf_bus.data.wis),  64'(e.wis));
                chk("out_pc",   64'(ibuf_bus.data.pc),   64'(e.pc));
                chk("out_uuid", 64'(ibuf_bus.data.uuid), 64'(e.uuid));
                chk("out_imm",  64'(ibuf_bus.data.imm),  64'(e.imm));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        decode_bus.valid = 1'b0;
        decode_bus.data  = '0;
        decode_wis       = '0;
        ibuf_bus.ready   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(ibuf_bus.valid), 64'(0));
        chk("rst_empty", 64'(ibuf_empty), 64'hF);
        chk("rst_pop",   64'(ibuf_pop), 64'(0));
        @(posedge clk); #1 rst = 1'b0;

        // Single push: 2-cycle latency, pop pulse in between
        ibuf_bus.ready = 1'b1;
        expect_out(2, 32'h8000_0000);
        push(2, 32'h8000_0000, stall);
        @(negedge clk);
        chk("single_pop",    64'(ibuf_pop), 64'b0100);
        chk("single_valid0", 64'(ibuf_bus.valid), 64'(0));
        chk("single_empty0", 64'(ibuf_empty), 64'b1011);
        @(negedge clk);
        chk("single_valid1", 64'(ibuf_bus.valid), 64'(1));
        chk("single_pop1",   64'(ibuf_pop), 64'(0));
        chk("single_empty1", 64'(ibuf_empty), 64'hF);
        repeat (3) @(posedge clk); #1;

        // Fairness: w0 head goes straight into the output register, then round-robin from warp 1
        ibuf_bus.ready = 1'b0;
        for (int k = 0; k < 2; k++)
            for (int w = 0; w < 4; w++) expect_out(w, 32'h1000 + w * 32'h100 + k * 4);
        expect_out(0, 32'h1008);
        for (int k = 0; k < 3; k++) push(0, 32'h1000 + k * 4, stall);
        for (int w = 1; w < 4; w++)
            for (int k = 0; k < 2; k++) push(w, 32'h1000 + w * 32'h100 + k * 4, stall);
        ibuf_bus.ready = 1'b1;
        repeat (9) @(posedge clk); #1;
        @(negedge clk);
        chk("fair_valid_done", 64'(ibuf_bus.valid), 64'(0));
        chk("fair_drained",    64'(exp_q.size()), 64'(0));
        chk("fair_empty",      64'(ibuf_empty), 64'hF);
        @(posedge clk); #1;

        // Backpressure: warp 1 held for 5 cycles
        ibuf_bus.ready = 1'b0;
        expect_out(1, 32'h100);
        expect_out(2, 32'h200);
        expect_out(3, 32'h300);
        push(1, 32'h100, stall);
        push(2, 32'h200, stall);
        push(3, 32'h300, stall);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", 64'(ibuf_bus.valid), 64'(1));
            chk("bp_wis",   64'(ibuf_bus.data.wis), 64'(1));
            chk("bp_pc",    64'(ibuf_bus.data.pc), 64'h100);
            chk("bp_pop",   64'(ibuf_pop), 64'(0));
            chk("bp_empty", 64'(ibuf_empty), 64'b0011);
        end
        @(posedge clk); #1 ibuf_bus.ready = 1'b1;
        @(negedge clk);
        chk("bp_release_pop", 64'(ibuf_pop), 64'b0100);
        @(negedge clk);
        chk("bp_next_pop", 64'(ibuf_pop), 64'b1000);
        repeat (3) @(posedge clk); #1;
        chk("bp_drained", 64'(exp_q.size()), 64'(0));

        // Full rejection on warp 0 with the output register occupied
        ibuf_bus.ready = 1'b0;
        expect_out(1, 32'h500);
        expect_out(0, 32'h600);
        expect_out(0, 32'h604);
        expect_out(0, 32'h608);
        push(1, 32'h500, stall);
        push(0, 32'h600, stall);
        push(0, 32'h604, stall);
        decode_wis = 2'd0;
        @(negedge clk);
        chk("full_ready_w0", 64'(decode_bus.ready), 64'(0));
        decode_wis = 2'd1;
        #1;
        chk("full_ready_w1", 64'(decode_bus.ready), 64'(1));
        @(posedge clk); #1;
        fork
            push(0, 32'h608, stall);
            begin
                repeat (3) @(posedge clk);
                #1 ibuf_bus.ready = 1'b1;
            end
        join
        chk("full_stall_cycles", 64'(stall), 64'(4));
        repeat (5) @(posedge clk); #1;
        chk("full_drained", 64'(exp_q.size()), 64'(0));

        // Per-warp order under a toggling consumer
        expect_out(3, 32'h10);
        expect_out(3, 32'h14);
        expect_out(3, 32'h18);
        fork
            begin
                push(3, 32'h10, stall);
                push(3, 32'h14, stall);
                push(3, 32'h18, stall);
            end
            begin
                repeat (20) begin
                    @(posedge clk);
                    #1 ibuf_bus.ready = ~ibuf_bus.ready;
                end
            end
        join
        ibuf_bus.ready = 1'b1;
        repeat (4) @(posedge clk); #1;
        chk("order_drained", 64'(exp_q.size()), 64'(0));

        // Asynchronous reset mid-operation
        ibuf_bus.ready = 1'b0;
        push(0, 32'hA00, stall);
        push(1, 32'hA04, stall);
        push(2, 32'hA08, stall);
        @(negedge clk);
        chk("pre_rst_valid", 64'(ibuf_bus.valid), 64'(1));
        chk("pre_rst_empty", 64'(ibuf_empty), 64'b1001);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(ibuf_bus.valid), 64'(0));
        chk("async_rst_empty", 64'(ibuf_empty), 64'hF);
        chk("async_rst_pop",   64'(ibuf_pop), 64'(0));
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        ibuf_bus.ready = 1'b1;
        expect_out(3, 32'hB00);
        push(3, 32'hB00, stall);
        @(negedge clk);
        chk("post_rst_pop",    64'(ibuf_pop), 64'b1000);
        chk("post_rst_valid0", 64'(ibuf_bus.valid), 64'(0));
        @(negedge clk);
        chk("post_rst_valid1", 64'(ibuf_bus.valid), 64'(1));
        repeat (3) @(posedge clk); #1;
        chk("final_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vx_scalar_ibuffer.md
Name: VX_scalar_ibuffer

Overview:
- Transmitter (master) side of the scalar instruction-buffer channel: valid/data/ready, where data carries uuid, wis, tmask, ex_type, op_type, op_mod, wb, use_PC, use_imm, PC, imm, rd, rs1, rs2 and rs3.
- One instance per issue slot. Decoded instructions are queued in per-warp FIFOs.
- Each cycle one non-empty warp is picked round-robin and its head instruction is presented through a registered output stage to the downstream consumer (scoreboard/dispatch).

Parameters:
- THREAD_CNT, `NUM_THREADS, thread-mask width.
- ISSUE_CNT, `ISSUE_WIDTH, issue slots; used only to derive PER_ISSUE_WARPS.
- WARP_CNT, `NUM_WARPS, total warps.
- DEPTH, 2, entries per warp FIFO; must be a power of two and at least 2.
- Derived: PER_ISSUE_WARPS = WARP_CNT/ISSUE_CNT; ISSUE_WIS_W = `LOG2UP(PER_ISSUE_WARPS); DATA_W = width of the ibuffer data struct.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- decode_valid  in  1  decoded instruction valid
- decode_wis  in  ISSUE_WIS_W  target warp index within this issue slot
- decode_data  in  DATA_W  instruction payload; its wis field is ignored
- decode_ready  out  1  equals !full[decode_wis]
- ibuf_valid  out  1  output instruction valid
- ibuf_data  out  DATA_W  output payload; wis field is the source warp index
- ibuf_ready  in  1  consumer accepts
- ibuf_pop  out  PER_ISSUE_WARPS  one-hot pulse, asserted the cycle a warp FIFO head is dequeued
- ibuf_empty  out  PER_ISSUE_WARPS  per-warp FIFO empty flags, for the warp scheduler

Behaviour:
- Reset (asynchronous, active-high) clears all of the following regardless of pending traffic:
  - all FIFO counts and pointers to 0;
  - ibuf_valid = 0;
  - rr_ptr = 0;
  - ibuf_pop = 0;
  - ibuf_empty = all 1s.
- ibuf_data contents after reset are don't-care. An instruction held in the output register when reset asserts is discarded.
- Push: decode_valid && decode_ready writes fifo[decode_wis] at the clock edge and increments its count.
  - decode_ready is combinational from the full flag only. There is no bypass: a full FIFO rejects a push even if it pops in the same cycle.
- Output register load condition: load_en = !ibuf_valid || ibuf_ready.
- Selection: when load_en is true, choose the first warp w with !empty[w], scanning circularly from rr_ptr.
  - Pop fifo[w]; ibuf_pop[w] = 1 that cycle, combinationally.
  - Load the register with fifo[w] head, with wis overwritten to w.
  - ibuf_valid is 1 in the next cycle.
  - rr_ptr becomes (w+1) mod PER_ISSUE_WARPS.
- If load_en is true and all FIFOs are empty: ibuf_valid becomes 0 and rr_ptr is unchanged.
- Hold: while ibuf_valid && !ibuf_ready, ibuf_data and ibuf_valid stay stable and no pop occurs.
- Throughput: one instruction per cycle while the consumer stays ready.
- Latency: push accepted at the end of cycle t gives earliest ibuf_valid in cycle t+2.
  - A FIFO written in cycle t is not selectable in cycle t.
- Same warp pushed and popped in the same cycle: count is unchanged and pointers both advance.
- FIFO pointers wrap modulo DEPTH.
- Count width is $clog2(DEPTH)+1.
  - full[w] = (count == DEPTH).
  - empty[w] = (count == 0).
  - ibuf_empty reflects registered counts.
- Order is preserved within a warp. No ordering is guaranteed across warps beyond round-robin fairness: a warp that is continuously non-empty is served at least once every PER_ISSUE_WARPS grants.
- PER_ISSUE_WARPS = 1: rr_ptr degenerates to a constant 0, and behaviour reduces to a single FIFO plus the output register.

Decomposition:
- VX_gpu_pkg holds the ibuffer data struct typedef and a PER_ISSUE_WARPS/ISSUE_WIS_W localparam helper, shared by the interface and this block.
- One sub-module, VX_scalar_ibuf_fifo: a single-warp, DEPTH-entry synchronous FIFO.
  - Inputs: push, pop, din.
  - Outputs: dout (head), full, empty.
  - Asynchronous active-high reset; instantiated PER_ISSUE_WARPS times via generate.
- The round-robin scan and the output register stay in the top module.

Test Plan (WARP_CNT=4, ISSUE_CNT=1, DEPTH=2):
- Single push: warp 2, PC=0x80000000, pushed in cycle 1, ibuf_ready=1 → ibuf_valid=1 in cycle 3 with wis=2 and PC=0x80000000; ibuf_pop=4'b0100 in cycle 2; ibuf_empty back to 4'b1111 in cycle 3.
- Fairness: warps 0–3 each preloaded with 2 instructions, ibuf_ready=1 → output wis sequence 0,1,2,3,0,1,2,3, one per cycle.
- Backpressure: ibuf_ready=0 for 5 cycles with a valid output (wis=1, PC=0x100) → ibuf_data stable, ibuf_pop=0 and FIFOs unchanged throughout; on ibuf_ready=1 the next warp is presented the following cycle.
- Full rejection: 2 pushes to warp 0 with ibuf_ready=0 and the output register already occupied → decode_ready=0 while decode_wis=0, and decode_ready=1 while decode_wis=1; a third warp-0 push is stalled with no data loss.
- Per-warp order: warp 3 pushed with PC=0x10, 0x14, 0x18 under a ready/not-ready consumer toggling every cycle → warp-3 outputs appear in order 0x10, 0x14, 0x18 with no duplicates.
- Reset mid-operation: assert reset asynchronously with the output valid and FIFOs partly full → ibuf_valid=0 and ibuf_empty=4'b1111 immediately, without waiting for a clock; after release, the first push is served at 2-cycle latency with rr_ptr starting at 0.
